// File: rtl/link_rr_arbiter.sv
// link_rr_arbiter: round-robin, packet-locking arbiter that shares one
// valid/stall link among P requesters. It feeds the write side of a mesochronous
// FIFO. A winner keeps the link until it sends a word with last=1.
// Optional per-requester packet counters: define LINK_RR_ARBITER_STATS_EN.
module link_rr_arbiter #(
    parameter int N  = 32,
    parameter int P  = 4,
    parameter int PW = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [P*N-1:0] i_data,
    input  logic [P-1:0]   i_last,
    input  logic [P-1:0]   i_valid,
    output logic [P-1:0]   o_stall,
    output logic [N-1:0]   o_data,
    output logic           o_last,
    output logic           o_valid,
    input  logic           i_stall,
    output logic [P-1:0]   o_grant,
    output logic           o_busy
`ifdef LINK_RR_ARBITER_STATS_EN
    ,
    input  logic            i_cnt_clr,
    output logic [P*16-1:0] o_pkt_cnt
`endif
);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic [PW-1:0]   own_q, own_d;

    logic            found;
    logic [PW-1:0]   win;
    logic [PW:0]     cand;
    logic [PW-1:0]   sel;
    logic [P-1:0]    grant;
    logic            valid;
    logic            busy;
    logic            xfer;

    // Pointer increment modulo P; also correct when P is not a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(P - 1)) ? '0 : p + PW'(1);
    endfunction

    // Round-robin search starting at rr_q; scanned from the far end so the
    // requester closest to rr_q overwrites the others and wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = P - 1; i >= 0; i--) begin
            cand = {1'b0, rr_q} + (PW + 1)'(i);
            if (cand >= (PW + 1)'(P)) cand = cand - (PW + 1)'(P);
            if (i_valid[cand[PW-1:0]]) begin
                found = 1'b1;
                win   = cand[PW-1:0];
            end
        end
    end

    // Next-state and link outputs; an IDLE grant is not remembered unless a
    // non-last word actually transfers.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        own_d   = own_q;
        sel     = own_q;
        grant   = '0;
        valid   = 1'b0;
        busy    = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    sel   = win;
                    grant = P'(1) << win;
                    valid = i_valid[win];
                    if (valid && !i_stall) begin
                        if (i_last[win]) begin
                            rr_d = ptr_inc(win);
                        end else begin
                            state_d = LOCK;
                            own_d   = win;
                        end
                    end
                end
            end
            LOCK: begin
                sel   = own_q;
                grant = P'(1) << own_q;
                valid = i_valid[own_q];
                busy  = 1'b1;
                if (valid && !i_stall && i_last[own_q]) begin
                    state_d = IDLE;
                    rr_d    = ptr_inc(own_q);
                end
            end
            default: state_d = IDLE;
        endcase
        // Hold the link quiet while in reset, even if requesters are valid.
        if (!rst_n) begin
            grant = '0;
            valid = 1'b0;
            busy  = 1'b0;
        end
    end

    // Data/last mux from the selected requester.
    always_comb begin
        o_data = '0;
        o_last = 1'b0;
        for (int k = 0; k < P; k++) begin
            if (sel == PW'(k)) begin
                o_data = i_data[k*N +: N];
                o_last = i_last[k];
            end
        end
    end

    assign o_grant = grant;
    assign o_valid = valid;
    assign o_busy  = busy;
    assign o_stall = ~grant | {P{i_stall}};
    assign xfer    = valid & ~i_stall;

    // State, round-robin pointer and owner registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            own_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            own_q   <= own_d;
        end
    end

`ifdef LINK_RR_ARBITER_STATS_EN
    logic [P-1:0][15:0] cnt_q, cnt_d;

    // Saturating completed-packet counters; clear wins over an increment.
    always_comb begin
        cnt_d = cnt_q;
        for (int k = 0; k < P; k++) begin
            if (i_cnt_clr) begin
                cnt_d[k] = '0;
            end else if (xfer && o_last && grant[k] && cnt_q[k] != 16'hFFFF) begin
                cnt_d[k] = cnt_q[k] + 16'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign o_pkt_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_link_rr_arbiter.sv
// Directed bench for link_rr_arbiter (P=4, N=32). Sources are modelled as
// per-requester packet generators that advance only when their word is taken.
module tb_link_rr_arbiter;

    localparam int N = 32;
    localparam int P = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [P*N-1:0] i_data;
    logic [P-1:0]   i_last;
    logic [P-1:0]   i_valid;
    logic [P-1:0]   o_stall;
    logic [N-1:0]   o_data;
    logic           o_last;
    logic           o_valid;
    logic           i_stall;
    logic [P-1:0]   o_grant;
    logic           o_busy;
`ifdef LINK_RR_ARBITER_STATS_EN
    logic            i_cnt_clr;
    logic [P*16-1:0] o_pkt_cnt;
`endif

    int ntests = 0;
    int nfail  = 0;

    // Source model: packets left, packet length, word position, forced bubble.
    int pl[P];
    int ln[P];
    int wp[P];
    bit bub[P];

    logic [31:0] xq[$];
    logic        xl[$];

    always #5 clk = ~clk;

    link_rr_arbiter #(.N(N), .P(P), .PW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_data(i_data), .i_last(i_last), .i_valid(i_valid),
        .o_stall(o_stall), .o_data(o_data), .o_last(o_last), .o_valid(o_valid),
        .i_stall(i_stall), .o_grant(o_grant), .o_busy(o_busy)
`ifdef LINK_RR_ARBITER_STATS_EN
        , .i_cnt_clr(i_cnt_clr), .o_pkt_cnt(o_pkt_cnt)
`endif
    );

    function automatic logic [31:0] wd(input int k, input int p, input int w);
        return {8'(k), 8'(p), 16'(w)};
    endfunction

    task automatic drive();
        for (int k = 0; k < P; k++) begin
            i_valid[k]       = (pl[k] > 0) && !bub[k];
            i_data[k*N +: N] = wd(k, pl[k], wp[k]);
            i_last[k]        = (wp[k] == ln[k] - 1);
        end
    endtask

    task automatic load(input int k, input int npk, input int len);
        pl[k] = npk; ln[k] = len; wp[k] = 0; bub[k] = 1'b0;
    endtask

    // Called at negedge+1: log the link transfer, let the clock edge happen,
    // then advance every source whose word was taken.
    task automatic tick();
        bit taken[P];
        for (int k = 0; k < P; k++) taken[k] = i_valid[k] && !o_stall[k];
        if (o_valid && !i_stall) begin
            xq.push_back(o_data);
            xl.push_back(o_last);
        end
        @(posedge clk); #1;
        for (int k = 0; k < P; k++) begin
            if (taken[k]) begin
                if (wp[k] == ln[k] - 1) begin
                    pl[k]--; wp[k] = 0;
                end else begin
                    wp[k]++;
                end
            end
        end
        drive();
        @(negedge clk); #1;
    endtask

    task automatic run_until(input int n, input int budget, input string nm);
        int c = 0;
        while (xq.size() < n && c < budget) begin
            tick();
            c++;
        end
        ntests++;
        if (xq.size() < n) begin
            nfail++;
            $display("FAIL %s timeout: got %0d transfers, need %0d", nm, xq.size(), n);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < P; k++) load(k, 0, 1);
        i_stall = 1'b0;
        rst_n = 1'b0;
        load(1, 1, 1);             // a valid requester must still see no grant
        drive();
        @(negedge clk); #1;
        ntests++; if (o_valid !== 1'b0) begin nfail++; $display("FAIL rst_valid got %b exp 0", o_valid); end
        ntests++; if (o_grant !== 4'b0000) begin nfail++; $display("FAIL rst_grant got %b exp 0000", o_grant); end
        ntests++; if (o_stall !== 4'b1111) begin nfail++; $display("FAIL rst_stall got %b exp 1111", o_stall); end
        ntests++; if (o_busy !== 1'b0) begin nfail++; $display("FAIL rst_busy got %b exp 0", o_busy); end
        load(1, 0, 1);
        drive();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        ntests++; if (o_valid !== 1'b0) begin nfail++; $display("FAIL idle_valid got %b exp 0", o_valid); end
        ntests++; if (o_grant !== 4'b0000) begin nfail++; $display("FAIL idle_grant got %b exp 0000", o_grant); end
        ntests++; if (o_stall !== 4'b1111) begin nfail++; $display("FAIL idle_stall got %b exp 1111", o_stall); end
    endtask

    task automatic test_round_robin();
        xq.delete(); xl.delete();
        for (int k = 0; k < P; k++) load(k, 1, 3);
        drive(); #1;
        ntests++; if (o_grant !== 4'b0001 || o_valid !== 1'b1) begin
            nfail++; $display("FAIL rr_first_grant got %b/%b exp 0001/1", o_grant, o_valid); end
        run_until(12, 40, "rr_xfers");
        for (int k = 0; k < P; k++) begin
            for (int w = 0; w < 3; w++) begin
                if (xq.size() > k*3 + w) begin
                    ntests++;
                    if (xq[k*3+w] !== wd(k, 1, w) || xl[k*3+w] !== (w == 2)) begin
                        nfail++;
                        $display("FAIL rr_order[%0d] got %h/%b exp %h/%b", k*3+w, xq[k*3+w], xl[k*3+w], wd(k, 1, w), (w == 2));
                    end
                end
            end
        end
        ntests++; if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
            nfail++; $display("FAIL rr_end_idle got busy %b valid %b exp 0/0", o_busy, o_valid); end
    endtask

    task automatic test_lock_bubble();
        xq.delete(); xl.delete();
        load(2, 1, 4);
        drive(); #1;
        ntests++; if (o_grant !== 4'b0100) begin nfail++; $display("FAIL lock_win got %b exp 0100", o_grant); end
        tick();
        load(1, 1, 1);
        bub[2] = 1'b1;
        drive(); #1;
        for (int c = 0; c < 3; c++) begin
            ntests++;
            if (o_grant !== 4'b0100 || o_stall[1] !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b1) begin
                nfail++;
                $display("FAIL lock_bubble c%0d got grant %b stall1 %b valid %b busy %b exp 0100/1/0/1", c, o_grant, o_stall[1], o_valid, o_busy);
            end
            tick();
        end
        bub[2] = 1'b0;
        drive(); #1;
        run_until(5, 20, "lock_xfers");
        for (int i = 0; i < 5; i++) begin
            logic [31:0] e;
            e = (i < 4) ? wd(2, 1, i) : wd(1, 1, 0);
            if (xq.size() > i) begin
                ntests++;
                if (xq[i] !== e) begin nfail++; $display("FAIL lock_order[%0d] got %h exp %h", i, xq[i], e); end
            end
        end
    endtask

    task automatic test_stall();
        xq.delete(); xl.delete();
        load(0, 1, 3);
        drive(); #1;
        tick();
        i_stall = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            ntests++;
            if (o_stall !== 4'b1111 || o_valid !== 1'b1 || o_grant !== 4'b0001 || o_data !== wd(0, 1, 1)) begin
                nfail++;
                $display("FAIL stall_hold c%0d got stall %b valid %b grant %b data %h exp 1111/1/0001/%h", c, o_stall, o_valid, o_grant, o_data, wd(0, 1, 1));
            end
            tick();
        end
        ntests++; if (xq.size() != 1) begin nfail++; $display("FAIL stall_noxfer got %0d exp 1", xq.size()); end
        i_stall = 1'b0;
        #1;
        tick();
        ntests++; if (xq.size() != 2 || xq[xq.size()-1] !== wd(0, 1, 1)) begin
            nfail++; $display("FAIL stall_resume got n=%0d last %h exp n=2 %h", xq.size(), xq[xq.size()-1], wd(0, 1, 1)); end
        run_until(3, 10, "stall_finish");
    endtask

    task automatic test_wrap();
        // rr_q is 1 here; a lone single word from 2 moves it to 3.
        xq.delete(); xl.delete();
        load(2, 1, 1);
        drive(); #1;
        run_until(1, 5, "wrap_prep");
        load(0, 1, 1);
        load(3, 1, 1);
        drive(); #1;
        ntests++; if (o_grant !== 4'b1000) begin nfail++; $display("FAIL wrap_first got %b exp 1000", o_grant); end
        run_until(3, 10, "wrap_xfers");
        ntests++; if (xq.size() < 3 || xq[1] !== wd(3, 1, 0) || xq[2] !== wd(0, 1, 0)) begin
            nfail++; $display("FAIL wrap_order got %h,%h exp %h,%h", xq[1], xq[2], wd(3, 1, 0), wd(0, 1, 0)); end
        // rr_q should now be 1: requester 1 beats requester 0.
        load(0, 1, 1);
        load(1, 1, 1);
        drive(); #1;
        ntests++; if (o_grant !== 4'b0010) begin nfail++; $display("FAIL wrap_rr1 got %b exp 0010", o_grant); end
        run_until(5, 10, "wrap_rr1_xfers");
    endtask

    task automatic test_reset_mid_packet();
        load(3, 1, 3);
        drive(); #1;
        tick();
        ntests++; if (o_busy !== 1'b1 || o_grant !== 4'b1000) begin
            nfail++; $display("FAIL midrst_lock got busy %b grant %b exp 1/1000", o_busy, o_grant); end
        rst_n = 1'b0;
        #1;
        ntests++; if (o_busy !== 1'b0 || o_stall !== 4'b1111 || o_valid !== 1'b0) begin
            nfail++; $display("FAIL midrst_clear got busy %b stall %b valid %b exp 0/1111/0", o_busy, o_stall, o_valid); end
        load(3, 0, 1);
        drive();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        load(2, 1, 1);
        load(1, 1, 1);
        drive(); #1;
        // rr_q back to 0 after reset: requester 1 ahead of 2.
        ntests++; if (o_grant !== 4'b0010 || o_busy !== 1'b0) begin
            nfail++; $display("FAIL midrst_idle got grant %b busy %b exp 0010/0", o_grant, o_busy); end
        xq.delete(); xl.delete();
        run_until(2, 10, "midrst_xfers");
    endtask

`ifdef LINK_RR_ARBITER_STATS_EN
    task automatic test_stats();
        xq.delete(); xl.delete();
        load(1, 5, 2);
        drive(); #1;
        run_until(10, 40, "stats_xfers");
        ntests++; if (o_pkt_cnt[31:16] !== 16'd5) begin nfail++; $display("FAIL stats_cnt got %0d exp 5", o_pkt_cnt[31:16]); end
        ntests++; if (o_pkt_cnt[15:0] !== 16'd0) begin nfail++; $display("FAIL stats_cnt0 got %0d exp 0", o_pkt_cnt[15:0]); end
        load(1, 1, 1);
        i_cnt_clr = 1'b1;
        drive(); #1;
        tick();
        i_cnt_clr = 1'b0;
        #1;
        ntests++; if (xq.size() != 11) begin nfail++; $display("FAIL stats_clr_xfer got %0d exp 11", xq.size()); end
        ntests++; if (o_pkt_cnt[31:16] !== 16'd0) begin nfail++; $display("FAIL stats_clr got %0d exp 0", o_pkt_cnt[31:16]); end
    endtask
`endif

    initial begin
        rst_n   = 1'b0;
        i_stall = 1'b0;
        i_valid = '0;
        i_last  = '0;
        i_data  = '0;
`ifdef LINK_RR_ARBITER_STATS_EN
        i_cnt_clr = 1'b0;
`endif
        test_reset();
        test_round_robin();
        test_lock_bubble();
        test_stall();
        test_wrap();
        test_reset_mid_packet();
`ifdef LINK_RR_ARBITER_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
